vedic_mul_arb: RTL and testbench

VEDIC_MUL_ARB -- requirements
Module: vedic_mul_arb

---
 rtl/vedic_mul_arb_if.sv | 49 ++++
 rtl/vedic_mul_arb.sv | 152 +++++++++++++++
 tb/tb_vedic_mul_arb.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vedic_mul_arb_if.sv
// Shared types and the requester/multiplier signal bundle for vedic_mul_arb.
package vedic_mul_arb_pkg;
  localparam int RISCV_V_DATA_WIDTH = 32;
  // Element size code: 0 = 8 bit, 1 = 16 bit, 2 = 32 bit, 3 = 64 bit
  typedef logic [1:0] osize_vector_t;
  typedef logic [1:0] riscv_v_merge_data_t;
endpackage

interface vedic_mul_arb_if #(
  parameter int DATA_WIDTH = vedic_mul_arb_pkg::RISCV_V_DATA_WIDTH,
  parameter int NUM_REQ    = 2
);
  // Requester side, indexed by requester id
  logic [NUM_REQ-1:0]                            req_valid;
  logic [NUM_REQ-1:0]                            req_ready;
  logic [DATA_WIDTH-1:0]                         req_A [NUM_REQ];
  logic [DATA_WIDTH-1:0]                         req_B [NUM_REQ];
  logic [NUM_REQ-1:0]                            req_is_signed;
  vedic_mul_arb_pkg::osize_vector_t              req_osize_vector [NUM_REQ];
  vedic_mul_arb_pkg::riscv_v_merge_data_t        req_merge [NUM_REQ];
  logic [NUM_REQ-1:0]                            rsp_valid;
  logic [NUM_REQ-1:0]                            rsp_ready;
  logic [2*DATA_WIDTH-1:0]                       rsp_Z [NUM_REQ];

  // Shared multiplier side
  logic                                          mul_valid;
  logic [DATA_WIDTH-1:0]                         mul_A;
  logic [DATA_WIDTH-1:0]                         mul_B;
  logic                                          mul_is_signed;
  vedic_mul_arb_pkg::osize_vector_t              mul_osize_vector;
  vedic_mul_arb_pkg::riscv_v_merge_data_t        mul_merge;
  logic [2*DATA_WIDTH-1:0]                       mul_Z;

  logic                                          flush;

  modport slave (
    input  req_valid, req_A, req_B, req_is_signed, req_osize_vector, req_merge,
    input  rsp_ready, mul_Z, flush,
    output req_ready, rsp_valid, rsp_Z,
    output mul_valid, mul_A, mul_B, mul_is_signed, mul_osize_vector, mul_merge
  );

  modport master (
    output req_valid, req_A, req_B, req_is_signed, req_osize_vector, req_merge,
    output rsp_ready, mul_Z, flush,
    input  req_ready, rsp_valid, rsp_Z,
    input  mul_valid, mul_A, mul_B, mul_is_signed, mul_osize_vector, mul_merge
  );
endinterface

// File: rtl/vedic_mul_arb.sv
// Two-requester round-robin front end for a shared pipelined multiplier.
// Each requester owns a small result FIFO; credits stop a requester from
// issuing more operations than its FIFO can ever hold, so pushes never overflow.
module vedic_mul_arb #(
  parameter int DATA_WIDTH  = vedic_mul_arb_pkg::RISCV_V_DATA_WIDTH,
  parameter int MUL_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_REQ     = 2
) (
  input logic            clk,
  input logic            rst,
  vedic_mul_arb_if.slave bus
);
  import vedic_mul_arb_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_SUM = (CW+1)'(FIFO_DEPTH);

  logic [CW-1:0]           wr_ptr       [NUM_REQ];
  logic [CW-1:0]           rd_ptr       [NUM_REQ];
  logic [CW-1:0]           inflight_cnt [NUM_REQ];
  logic [CW-1:0]           fifo_cnt     [NUM_REQ];
  logic [2*DATA_WIDTH-1:0] fifo_mem     [NUM_REQ][FIFO_DEPTH];

  logic [NUM_REQ-1:0] credit;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] fifo_nonempty;

  logic rr_ptr;
  logic gnt_any;
  logic gnt_id;

  // Tag stage 0 lines up with mul_valid; stage MUL_LATENCY lines up with mul_Z
  logic [MUL_LATENCY:0] tag_v;
  logic [MUL_LATENCY:0] tag_id;

  logic [DATA_WIDTH-1:0] mul_a_q;
  logic [DATA_WIDTH-1:0] mul_b_q;
  logic                  mul_signed_q;
  osize_vector_t         mul_osize_q;
  riscv_v_merge_data_t   mul_merge_q;

  // Credit, eligibility and FIFO push/pop qualifiers from registered counts only
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      fifo_cnt[i]      = wr_ptr[i] - rd_ptr[i];
      fifo_nonempty[i] = (wr_ptr[i] != rd_ptr[i]);
      credit[i]        = ({1'b0, inflight_cnt[i]} + {1'b0, fifo_cnt[i]}) < DEPTH_SUM;
      eligible[i]      = bus.req_valid[i] & credit[i];
      pop[i]           = fifo_nonempty[i] & bus.rsp_ready[i];
      push[i]          = tag_v[MUL_LATENCY] & (tag_id[MUL_LATENCY] == 1'(i)) & ~bus.flush;
    end
  end

  // Round-robin pick: the pointed-to requester wins ties, nobody wins during flush/reset
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = rr_ptr;
    if (!rst && !bus.flush) begin
      if (eligible[rr_ptr]) begin
        gnt_any = 1'b1;
        gnt_id  = rr_ptr;
      end else if (eligible[~rr_ptr]) begin
        gnt_any = 1'b1;
        gnt_id  = ~rr_ptr;
      end
    end
  end

  // Requester-facing outputs: one-hot ready, FIFO head as the response
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = gnt_any & (gnt_id == 1'(i));
      bus.rsp_valid[i] = fifo_nonempty[i];
      bus.rsp_Z[i]     = fifo_mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  assign bus.mul_valid        = tag_v[0];
  assign bus.mul_A            = mul_a_q;
  assign bus.mul_B            = mul_b_q;
  assign bus.mul_is_signed    = mul_signed_q;
  assign bus.mul_osize_vector = mul_osize_q;
  assign bus.mul_merge        = mul_merge_q;

  // Issue stage: round-robin pointer, multiplier operand registers and tag pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= 1'b0;
      tag_v        <= '0;
      tag_id       <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_signed_q <= 1'b0;
      mul_osize_q  <= '0;
      mul_merge_q  <= '0;
    end else begin
      if (gnt_any) begin
        rr_ptr       <= ~gnt_id;
        mul_a_q      <= bus.req_A[gnt_id];
        mul_b_q      <= bus.req_B[gnt_id];
        mul_signed_q <= bus.req_is_signed[gnt_id];
        mul_osize_q  <= bus.req_osize_vector[gnt_id];
        mul_merge_q  <= bus.req_merge[gnt_id];
      end
      tag_v[0]  <= gnt_any;
      tag_id[0] <= gnt_id;
      for (int k = 1; k <= MUL_LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1] & ~bus.flush;
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // Result FIFOs and in-flight counters; flush empties everything but keeps storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i]       <= '0;
        rd_ptr[i]       <= '0;
        inflight_cnt[i] <= '0;
        for (int d = 0; d < FIFO_DEPTH; d++) begin
          fifo_mem[i][d] <= '0;
        end
      end
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i]       <= '0;
        rd_ptr[i]       <= '0;
        inflight_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) begin
          fifo_mem[i][wr_ptr[i][AW-1:0]] <= bus.mul_Z;
          wr_ptr[i] <= wr_ptr[i] + CW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + CW'(1);
        end
        case ({gnt_any & (gnt_id == 1'(i)), push[i]})
          2'b10:   inflight_cnt[i] <= inflight_cnt[i] + CW'(1);
          2'b01:   inflight_cnt[i] <= inflight_cnt[i] - CW'(1);
          default: inflight_cnt[i] <= inflight_cnt[i];
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vedic_mul_arb.sv
// Self-checking bench for vedic_mul_arb: a lane-wise multiplier model feeds mul_Z,
// and a transaction-level scoreboard predicts grants, response timing and values.
module tb_vedic_mul_arb;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  vedic_mul_arb_if #(.DATA_WIDTH(DW), .NUM_REQ(2)) bus ();

  vedic_mul_arb #(
    .DATA_WIDTH (DW),
    .MUL_LATENCY(LAT),
    .FIFO_DEPTH (DEPTH),
    .NUM_REQ    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] z;
    int          rdy;
  } exp_t;

  exp_t exp_q [2][$];
  int   outstanding [2];
  int   acc_cnt [2];
  int   prio;
  int   last_issue;
  int   cyc;
  int   checks;
  int   failures;
  logic [63:0] mp0;
  logic [63:0] mp1;

  // Lane-wise product: esz-bit elements produce 2*esz-bit results side by side
  function automatic logic [63:0] vmul(input logic [31:0] a, input logic [31:0] b,
                                       input logic sgn, input logic [1:0] osz);
    int esz;
    logic [63:0] z, ua, ub, m1, m2;
    longint ea, eb, p;
    esz = (osz >= 2'd2) ? 32 : (8 << osz);
    m1  = (64'd1 << esz) - 64'd1;
    m2  = (esz == 32) ? '1 : ((64'd1 << (2 * esz)) - 64'd1);
    z   = '0;
    for (int l = 0; l < 32 / esz; l++) begin
      ua = ({32'd0, a} >> (l * esz)) & m1;
      ub = ({32'd0, b} >> (l * esz)) & m1;
      ea = longint'(ua);
      eb = longint'(ub);
      if (sgn && ua[esz-1]) ea = ea - longint'(64'd1 << esz);
      if (sgn && ub[esz-1]) eb = eb - longint'(64'd1 << esz);
      p = ea * eb;
      z = z | ((64'(p) & m2) << (2 * esz * l));
    end
    return z;
  endfunction

  // External multiplier with LAT cycles of latency after mul_valid
  always @(posedge clk) begin
    mp0 <= vmul(bus.mul_A, bus.mul_B, bus.mul_is_signed, bus.mul_osize_vector);
    mp1 <= mp0;
  end
  assign bus.mul_Z = mp1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic setOp(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic [1:0] osz);
    bus.req_A[i]            = a;
    bus.req_B[i]            = b;
    bus.req_is_signed[i]    = sgn;
    bus.req_osize_vector[i] = osz;
    bus.req_merge[i]        = 2'($urandom_range(0, 3));
  endtask

  task automatic randOps();
    for (int i = 0; i < 2; i++) begin
      setOp(i, $urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)));
    end
  endtask

  // Drive one cycle from a falling edge, check just before the rising edge, update the model
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] rr, input logic fl);
    logic [1:0] elig;
    logic [1:0] ev;
    int gnt;
    exp_t e;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    bus.flush     = fl;
    #4;
    for (int i = 0; i < 2; i++) begin
      elig[i] = v[i] && (outstanding[i] < DEPTH) && !fl;
    end
    gnt = -1;
    if (elig[prio]) gnt = prio;
    else if (elig[1-prio]) gnt = 1 - prio;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("req_ready%0d", i), 64'(bus.req_ready[i]), 64'(gnt == i));
      if (bus.req_ready[i] && v[i]) acc_cnt[i]++;
      ev[i] = (exp_q[i].size() > 0) && (exp_q[i][0].rdy <= cyc);
      checkOutput($sformatf("rsp_valid%0d", i), 64'(bus.rsp_valid[i]), 64'(ev[i]));
      if (ev[i]) checkOutput($sformatf("rsp_Z%0d", i), bus.rsp_Z[i], exp_q[i][0].z);
    end
    checkOutput("mul_valid", 64'(bus.mul_valid), 64'(last_issue == cyc - 1));
    if (fl) begin
      for (int i = 0; i < 2; i++) begin
        exp_q[i].delete();
        outstanding[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ev[i] && rr[i]) begin
          void'(exp_q[i].pop_front());
          outstanding[i]--;
        end
      end
      if (gnt >= 0) begin
        e.z   = vmul(bus.req_A[gnt], bus.req_B[gnt], bus.req_is_signed[gnt],
                     bus.req_osize_vector[gnt]);
        e.rdy = cyc + LAT + 2;
        exp_q[gnt].push_back(e);
        outstanding[gnt]++;
        prio       = 1 - gnt;
        last_issue = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      outstanding[i] = 0;
    end
    prio       = 0;
    last_issue = -10;
  endtask

  // Hard stop in case anything stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0, a1;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    acc_cnt  = '{0, 0};
    modelReset();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    bus.flush     = 1'b0;
    setOp(0, 32'h1, 32'h1, 1'b0, 2'd0);
    setOp(1, 32'h1, 32'h1, 1'b0, 2'd0);

    // Reset state while requests are being offered
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_mul_valid", 64'(bus.mul_valid), 64'd0);
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("rst_mul_A", 64'(bus.mul_A), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single unsigned byte multiply on requester 0
    setOp(0, 32'h05, 32'h03, 1'b0, 2'd0);
    applyStimulus(2'b01, 2'b00, 1'b0);
    repeat (3) applyStimulus(2'b00, 2'b00, 1'b0);
    checkOutput("single_rsp_valid0", 64'(bus.rsp_valid[0]), 64'd1);
    checkOutput("single_lane_u8", 64'(bus.rsp_Z[0][15:0]), 64'h000F);
    applyStimulus(2'b00, 2'b01, 1'b0);

    // Signed byte multiply on requester 1
    setOp(1, 32'hFF, 32'h02, 1'b1, 2'd0);
    applyStimulus(2'b10, 2'b00, 1'b0);
    repeat (3) applyStimulus(2'b00, 2'b00, 1'b0);
    checkOutput("signed_rsp_valid1", 64'(bus.rsp_valid[1]), 64'd1);
    checkOutput("signed_lane_s8", 64'(bus.rsp_Z[1][15:0]), 64'hFFFE);
    applyStimulus(2'b00, 2'b10, 1'b0);

    // Contention: both requesters continuously valid
    a0 = acc_cnt[0];
    a1 = acc_cnt[1];
    repeat (8) begin
      randOps();
      applyStimulus(2'b11, 2'b11, 1'b0);
    end
    checkOutput("contend_acc0", 64'(acc_cnt[0] - a0), 64'd4);
    checkOutput("contend_acc1", 64'(acc_cnt[1] - a1), 64'd4);
    repeat (6) applyStimulus(2'b00, 2'b11, 1'b0);

    // Back-pressure on requester 0
    a0 = acc_cnt[0];
    repeat (8) begin
      randOps();
      applyStimulus(2'b01, 2'b00, 1'b0);
    end
    checkOutput("bp_accepted", 64'(acc_cnt[0] - a0), 64'd4);
    a0 = acc_cnt[0];
    applyStimulus(2'b01, 2'b01, 1'b0);
    repeat (6) applyStimulus(2'b01, 2'b00, 1'b0);
    checkOutput("bp_after_pop", 64'(acc_cnt[0] - a0), 64'd1);
    repeat (10) applyStimulus(2'b00, 2'b11, 1'b0);

    // Flush with two results queued and three in flight
    randOps();
    repeat (2) applyStimulus(2'b10, 2'b00, 1'b0);
    repeat (4) applyStimulus(2'b00, 2'b00, 1'b0);
    repeat (3) begin
      randOps();
      applyStimulus(2'b11, 2'b00, 1'b0);
    end
    applyStimulus(2'b11, 2'b00, 1'b1);
    checkOutput("flush_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("flush_mul_valid", 64'(bus.mul_valid), 64'd0);
    a0 = acc_cnt[0];
    repeat (6) begin
      randOps();
      applyStimulus(2'b01, 2'b00, 1'b0);
    end
    checkOutput("flush_credit0", 64'(acc_cnt[0] - a0), 64'd4);
    repeat (10) applyStimulus(2'b00, 2'b11, 1'b0);

    // Randomized traffic with occasional flushes
    repeat (250) begin
      randOps();
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 39) == 0));
    end

    // Burst, then asynchronous reset between clock edges
    repeat (6) begin
      randOps();
      applyStimulus(2'b11, 2'b00, 1'b0);
    end
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_mul_valid", 64'(bus.mul_valid), 64'd0);
    checkOutput("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("arst_req_ready", 64'(bus.req_ready), 64'd0);
    modelReset();
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    repeat (6) begin
      randOps();
      applyStimulus(2'b11, 2'b11, 1'b0);
    end
    repeat (60) begin
      randOps();
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
    end
    repeat (10) applyStimulus(2'b00, 2'b11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
